// File: rtl/iter_fb_reader.sv
// rtl/iter_fb_reader.sv - raster-order framebuffer reader with colour map and 2-deep output FIFO
// Optional multi-frame streaming is enabled by the FRAME_REPEAT_EN macro.
module iter_fb_reader #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int ADDR_W   = 15,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ITER_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_data,
    output logic              out_sof,
    output logic              out_eol
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] Y_LAST    = ADDR_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        last;
    } beat_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] x, y;
    logic              infl, infl_sof, infl_eol, infl_last;
    beat_t             head, skid, in_beat;
    logic              skid_valid;
    logic              pop, last_issue, drain_empty, done_r;
    logic [1:0]        pending;
    logic [7:0]        red;

    assign out_data = head.data;
    assign out_sof  = head.sof;
    assign out_eol  = head.eol;
    assign done     = done_r;

    always_comb begin
        pop        = out_valid && out_ready;
        // A beat leaving this cycle frees its slot, so back-to-back issue is possible at full rate.
        pending    = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, infl} - {1'b0, pop};
        rd_en      = (state == RUN) && (pending < 2'd2);
        last_issue = rd_en && (rd_addr == LAST_ADDR);
        red        = 8'(rd_data);
        in_beat.data = (rd_data == ITER_W'(MAX_ITER)) ? 24'h000000 : {red, 16'h0000};
        in_beat.sof  = infl_sof;
        in_beat.eol  = infl_eol;
        in_beat.last = infl_last;
        drain_empty  = (state == DRAIN) && !out_valid && !skid_valid && !infl;
        busy         = (state != IDLE) && !drain_empty;
        state_nxt    = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
`ifdef FRAME_REPEAT_EN
                state_nxt = RUN;
`else
                if (last_issue) state_nxt = DRAIN;
`endif
            end
            DRAIN:   if (drain_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            x          <= '0;
            y          <= '0;
            infl       <= 1'b0;
            infl_sof   <= 1'b0;
            infl_eol   <= 1'b0;
            infl_last  <= 1'b0;
            head       <= '0;
            skid       <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state  <= state_nxt;
            infl   <= rd_en;
            done_r <= pop && head.last;
            if (state == IDLE && start) begin
                rd_addr <= '0;
                x       <= '0;
                y       <= '0;
            end else if (rd_en) begin
                infl_sof  <= (x == '0) && (y == '0);
                infl_eol  <= (x == X_LAST);
                infl_last <= last_issue;
                rd_addr   <= last_issue ? '0 : rd_addr + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            // Head register is the visible FIFO slot; skid holds the second entry.
            if (pop) begin
                if (skid_valid) begin
                    head <= skid;
                    if (infl) skid <= in_beat;
                    else      skid_valid <= 1'b0;
                end else if (infl) begin
                    head <= in_beat;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (infl) begin
                if (!out_valid) begin
                    head      <= in_beat;
                    out_valid <= 1'b1;
                end else begin
                    skid       <= in_beat;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_fb_reader.sv
// tb/tb_iter_fb_reader.sv - scoreboard bench for iter_fb_reader on a 4x3 frame
module tb_iter_fb_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, rd_en, out_valid, out_sof, out_eol;
    logic        out_ready = 1'b0;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [23:0] out_data;

    iter_fb_reader #(.H_RES(4), .V_RES(3), .ADDR_W(15), .ITER_W(8), .MAX_ITER(255)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  val;
        logic [23:0] col;
    } cvec_t;

    cvec_t       ctab [12];
    logic [7:0]  mem [16];
    logic [25:0] exp_q [$];
    int          errors = 0, checks = 0;
    int          cyc = 0, start_cyc = 0;
    int          issued = 0, accepted = 0, done_cnt = 0;
    int          first_rd_cyc = -1, last_rd_cyc = -1, first_val_cyc = -1, done_cyc = -1;
    logic        busy_at_done = 1'b0;
    logic        stall_prev = 1'b0;
    logic [26:0] prev_out = '0;
    int          ready_mode = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data <= rd_en ? mem[rd_addr[3:0]] : 8'hA5;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_stable", {5'b0, out_valid, out_data, out_sof, out_eol}, {5'b0, prev_out});
            if (rd_en) begin
                if (issued == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                check("rd_addr", {17'b0, rd_addr}, issued % 12);
                issued++;
            end
            if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (out_valid && out_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL extra_beat: got %0h expected none", {out_data, out_sof, out_eol});
                end else begin
                    check("beat", {6'b0, out_data, out_sof, out_eol}, {6'b0, exp_q.pop_front()});
                end
            end
            if (rd_en) check("outstanding_le_2", 32'(issued - accepted <= 2), 32'd1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_data, out_sof, out_eol};
        end
    end

    task automatic clear_counters();
        issued = 0; accepted = 0; done_cnt = 0;
        first_val_cyc = -1; done_cyc = -1;
        exp_q.delete();
    endtask

    task automatic push_exp(input int i, input logic [23:0] col);
        logic sof, eol;
        sof = (i % 12 == 0);
        eol = (i % 4 == 3);
        exp_q.push_back({col, sof, eol});
    endtask

    task automatic load_ramp(input int beats);
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        for (int i = 0; i < beats; i++) push_exp(i, {8'(i % 12), 16'h0000});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_budget", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        ctab[0]  = '{8'd255, 24'h000000};
        ctab[1]  = '{8'd0,   24'h000000};
        ctab[2]  = '{8'd254, 24'hFE0000};
        ctab[3]  = '{8'd17,  24'h110000};
        ctab[4]  = '{8'd1,   24'h010000};
        ctab[5]  = '{8'd128, 24'h800000};
        ctab[6]  = '{8'd255, 24'h000000};
        ctab[7]  = '{8'd127, 24'h7F0000};
        ctab[8]  = '{8'd200, 24'hC80000};
        ctab[9]  = '{8'd64,  24'h400000};
        ctab[10] = '{8'd3,   24'h030000};
        ctab[11] = '{8'd250, 24'hFA0000};
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        idle_cycles(3);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_rd_en", {31'b0, rd_en}, 0);
        check("rst_rd_addr", {17'b0, rd_addr}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", {8'b0, out_data}, 0);
        check("rst_sof_eol", {30'b0, out_sof, out_eol}, 0);

`ifdef FRAME_REPEAT_EN
        ready_mode = 1;
        clear_counters();
        load_ramp(36);
        pulse_start();
        wait_done(3, 200);
        check("rep_beats_ge_36", 32'(accepted >= 36), 32'd1);
        check("rep_queue_empty", exp_q.size(), 0);
        check("rep_done_cnt", done_cnt, 3);
        check("rep_busy", {31'b0, busy}, 1);
        pulse_start();
        idle_cycles(5);
        check("rep_busy_after_start", {31'b0, busy}, 1);
`else
        // basic frame, full rate
        ready_mode = 1;
        clear_counters();
        load_ramp(12);
        pulse_start();
        wait_done(1, 100);
        check("basic_beats", accepted, 12);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_first_rd", first_rd_cyc, start_cyc + 1);
        check("basic_last_rd", last_rd_cyc, start_cyc + 12);
        check("basic_first_valid", first_val_cyc, start_cyc + 3);
        check("basic_done_cyc", done_cyc, start_cyc + 15);
        check("basic_busy_at_done", {31'b0, busy_at_done}, 0);
        idle_cycles(5);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_issued", issued, 12);
        check("basic_busy_idle", {31'b0, busy}, 0);

        // backpressure
        ready_mode = 2;
        clear_counters();
        load_ramp(12);
        pulse_start();
        wait_done(1, 400);
        idle_cycles(3);
        check("bp_beats", accepted, 12);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_done_cnt", done_cnt, 1);

        // colour map table
        ready_mode = 1;
        clear_counters();
        for (int i = 0; i < 12; i++) begin
            mem[i] = ctab[i].val;
            push_exp(i, ctab[i].col);
        end
        pulse_start();
        wait_done(1, 100);
        check("cmap_beats", accepted, 12);
        check("cmap_queue_empty", exp_q.size(), 0);

        // second start mid-frame is ignored
        clear_counters();
        load_ramp(12);
        pulse_start();
        for (int n = 0; n < 50 && accepted < 5; n++) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, 100);
        idle_cycles(20);
        check("restart_beats", accepted, 12);
        check("restart_issued", issued, 12);
        check("restart_done_cnt", done_cnt, 1);

        // reset mid-frame with downstream stalled
        clear_counters();
        load_ramp(12);
        pulse_start();
        for (int n = 0; n < 50 && accepted < 6; n++) begin
            @(posedge clk); #1;
        end
        ready_mode = 0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", {31'b0, busy}, 0);
        check("mrst_done", {31'b0, done}, 0);
        check("mrst_rd_en", {31'b0, rd_en}, 0);
        check("mrst_rd_addr", {17'b0, rd_addr}, 0);
        check("mrst_out_valid", {31'b0, out_valid}, 0);
        check("mrst_out_data", {8'b0, out_data}, 0);
        check("mrst_sof_eol", {30'b0, out_sof, out_eol}, 0);
        clear_counters();
        ready_mode = 1;
        idle_cycles(10);
        check("mrst_no_done", done_cnt, 0);
        check("mrst_no_beats", accepted, 0);
        load_ramp(12);
        pulse_start();
        wait_done(1, 100);
        check("mrst_clean_beats", accepted, 12);
        check("mrst_clean_queue", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
